nx_stream_distributor: RTL and testbench
========================================

NX_STREAM_DISTRIBUTOR -- requirements
Module: nx_stream_distributor

Interface
REQ-001 SHALL have parameter STREAM_WIDTH, default 32, width of the message data field.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, entries per egress FIFO; power of two, >= 2.
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port dist_data_i  input  STREAM_WIDTH  inbound message data.
REQ-006 SHALL have port dist_dir_i  input  2  inbound direction: 0=north, 1=east, 2=south, 3=west.
REQ-007 SHALL have port dist_valid_i  input  1  inbound message valid.
REQ-008 SHALL have port dist_ready_o  output  1  inbound message accepted when high with dist_valid_i.
REQ-009 SHALL have, for each X in {north, east, south, west}, port stream_X_data_o  output  STREAM_WIDTH  egress data.
REQ-010 SHALL have, per X, port stream_X_valid_o  output  1  egress valid.
REQ-011 SHALL have, per X, port stream_X_ready_i  input  1  egress ready from downstream.
REQ-012 SHALL have port idle_o  output  1  high when no message is held anywhere in the block.

Function
REQ-013 SHALL hold one ingress register (hold_valid, hold_data, hold_dir) plus one FIFO of FIFO_DEPTH entries per direction.
REQ-014 SHALL drive dist_ready_o = !hold_valid || !full[hold_dir]; never dependent on dist_valid_i, dist_data_i or dist_dir_i.
REQ-015 SHALL capture dist_data_i/dist_dir_i into the ingress register on a cycle where dist_valid_i && dist_ready_o.
REQ-016 SHALL transfer the held message into FIFO[hold_dir] on any cycle where hold_valid && !full[hold_dir]; the ingress register SHALL reload from the input in that same cycle if an input handshake occurs.
REQ-017 SHALL clear hold_valid when a transfer occurs without a simultaneous input handshake.
REQ-018 SHALL evaluate full[X] from the registered level (level == FIFO_DEPTH); a pop in the same cycle SHALL NOT permit a push into a full FIFO.
REQ-019 SHALL drive stream_X_valid_o = !empty[X] and stream_X_data_o = FIFO[X] head entry.
REQ-020 SHALL pop FIFO[X] when stream_X_valid_o && stream_X_ready_i; simultaneous push and pop on a non-full, non-empty FIFO SHALL leave level unchanged.
REQ-021 SHALL preserve message order per direction; ordering across different directions is not guaranteed beyond ingress order at FIFO write.
REQ-022 SHALL give minimum latency 2 cycles: input handshake at edge T, message in hold after T, written to FIFO at edge T+1, egress valid visible after edge T+1.
REQ-023 SHALL sustain one message per cycle when target FIFOs are not full, including back-to-back messages to the same direction.
REQ-024 SHALL stall only via the held message: a full FIFO for hold_dir blocks ingress (head-of-line); FIFOs for other directions SHALL continue to drain.
REQ-025 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH with a separate level counter 0..FIFO_DEPTH.
REQ-026 SHALL drive idle_o = !hold_valid && all four FIFOs empty.
REQ-027 SHALL hold stream_X_data_o stable while stream_X_valid_o is high and stream_X_ready_i is low.

Reset
REQ-028 SHALL on rst_i clear hold_valid, all FIFO pointers and levels, and all FIFO storage to zero.
REQ-029 SHALL during and immediately after reset drive dist_ready_o=1, all stream_X_valid_o=0, all stream_X_data_o=0, idle_o=1.
REQ-030 SHALL discard any held or queued message on reset asserted mid-operation, with no egress valid asserted on the following cycle.

Verification
REQ-031 Single message data=0xA5A5A5A5 dir=1, all ready high -> stream_east_valid_o high exactly one cycle, 2 cycles after handshake, data 0xA5A5A5A5; idle_o returns to 1.
REQ-032 Stream 4 messages dir=0,1,2,3 on consecutive cycles, all ready high -> each egress valid once, consecutive cycles, dist_ready_o constantly 1.
REQ-033 stream_south_ready_i=0, send 4 messages dir=2 (DEPTH=2) -> 2 in FIFO, 1 in hold, dist_ready_o=0 after third accept; raise ready -> all 3 delivered in order, 4th accepted once space frees.
REQ-034 South blocked and full with hold dir=2, then dir=0 offered -> dir=0 not accepted until south drains; north FIFO messages already queued still drain.
REQ-035 Full FIFO with simultaneous pop and held push -> push deferred one cycle, level goes 2->1->2, no loss or duplication.
REQ-036 Assert rst_i with messages in hold and FIFOs -> all valids 0, idle_o=1, dist_ready_o=1; post-reset traffic delivered normally.

Source files
------------

// File: rtl/nx_stream_distributor.sv
// Routes one inbound message stream to four directional egress FIFOs via a single
// ingress holding register; a full target FIFO stalls ingress (head-of-line).
module nx_stream_distributor #(
    parameter int unsigned STREAM_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [STREAM_WIDTH-1:0] dist_data_i,
    input  logic [1:0]              dist_dir_i,
    input  logic                    dist_valid_i,
    output logic                    dist_ready_o,
    output logic [STREAM_WIDTH-1:0] stream_north_data_o,
    output logic                    stream_north_valid_o,
    input  logic                    stream_north_ready_i,
    output logic [STREAM_WIDTH-1:0] stream_east_data_o,
    output logic                    stream_east_valid_o,
    input  logic                    stream_east_ready_i,
    output logic [STREAM_WIDTH-1:0] stream_south_data_o,
    output logic                    stream_south_valid_o,
    input  logic                    stream_south_ready_i,
    output logic [STREAM_WIDTH-1:0] stream_west_data_o,
    output logic                    stream_west_valid_o,
    input  logic                    stream_west_ready_i,
    output logic                    idle_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic                    r_hold_valid;
    logic [STREAM_WIDTH-1:0] r_hold_data;
    logic [1:0]              r_hold_dir;

    logic [3:0]              w_eg_ready;
    logic [3:0]              w_full;
    logic [3:0]              w_empty;
    logic [3:0]              w_push;
    logic [3:0]              w_pop;
    logic [STREAM_WIDTH-1:0] w_head [4];
    logic                    w_xfer;
    logic                    w_accept;

    assign w_eg_ready = {stream_west_ready_i, stream_south_ready_i,
                         stream_east_ready_i, stream_north_ready_i};

    // Fullness comes from the registered level only, so a same-cycle pop never admits a push.
    assign w_xfer       = r_hold_valid && !w_full[r_hold_dir];
    assign dist_ready_o = !r_hold_valid || !w_full[r_hold_dir];
    assign w_accept     = dist_valid_i && dist_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_hold_dir   <= '0;
        end else if (w_accept) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= dist_data_i;
            r_hold_dir   <= dist_dir_i;
        end else if (w_xfer) begin
            r_hold_valid <= 1'b0;
        end
    end

    for (genvar d = 0; d < 4; d++) begin : g_fifo
        logic [STREAM_WIDTH-1:0] r_mem [FIFO_DEPTH];
        logic [PW-1:0]           r_wptr;
        logic [PW-1:0]           r_rptr;
        logic [LW-1:0]           r_level;

        assign w_full[d]  = (r_level == LVL_FULL);
        assign w_empty[d] = (r_level == '0);
        assign w_push[d]  = w_xfer && (r_hold_dir == 2'(d));
        assign w_pop[d]   = !w_empty[d] && w_eg_ready[d];
        assign w_head[d]  = r_mem[r_rptr];

        // Pointers are PW bits wide, so they wrap modulo the power-of-two depth.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
                for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                    r_mem[i] <= '0;
                end
            end else begin
                if (w_push[d]) begin
                    r_mem[r_wptr] <= r_hold_data;
                    r_wptr        <= r_wptr + PTR_ONE;
                end
                if (w_pop[d]) begin
                    r_rptr <= r_rptr + PTR_ONE;
                end
                if (w_push[d] && !w_pop[d]) begin
                    r_level <= r_level + LVL_ONE;
                end else if (!w_push[d] && w_pop[d]) begin
                    r_level <= r_level - LVL_ONE;
                end
            end
        end
    end

    assign stream_north_valid_o = !w_empty[0];
    assign stream_east_valid_o  = !w_empty[1];
    assign stream_south_valid_o = !w_empty[2];
    assign stream_west_valid_o  = !w_empty[3];
    assign stream_north_data_o  = w_head[0];
    assign stream_east_data_o   = w_head[1];
    assign stream_south_data_o  = w_head[2];
    assign stream_west_data_o   = w_head[3];

    assign idle_o = !r_hold_valid && (&w_empty);

endmodule

// File: tb/tb_nx_stream_distributor.sv
// Directed bench for nx_stream_distributor: a cycle-by-cycle vector table plus
// hand-written sequences for deferred push and mid-operation reset.
module tb_nx_stream_distributor;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] dist_data_i;
    logic [1:0]  dist_dir_i;
    logic        dist_valid_i;
    logic        dist_ready_o;
    logic [31:0] n_data, e_data, s_data, w_data;
    logic        n_valid, e_valid, s_valid, w_valid;
    logic        n_ready, e_ready, s_ready, w_ready;
    logic        idle_o;

    int checks   = 0;
    int failures = 0;

    nx_stream_distributor #(.STREAM_WIDTH(32), .FIFO_DEPTH(2)) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .dist_data_i          (dist_data_i),
        .dist_dir_i           (dist_dir_i),
        .dist_valid_i         (dist_valid_i),
        .dist_ready_o         (dist_ready_o),
        .stream_north_data_o  (n_data),
        .stream_north_valid_o (n_valid),
        .stream_north_ready_i (n_ready),
        .stream_east_data_o   (e_data),
        .stream_east_valid_o  (e_valid),
        .stream_east_ready_i  (e_ready),
        .stream_south_data_o  (s_data),
        .stream_south_valid_o (s_valid),
        .stream_south_ready_i (s_ready),
        .stream_west_data_o   (w_data),
        .stream_west_valid_o  (w_valid),
        .stream_west_ready_i  (w_ready),
        .idle_o               (idle_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic             v;
        logic [1:0]       dir;
        logic [31:0]      data;
        logic [3:0]       rdy;
        logic             e_rdy;
        logic [3:0]       e_vld;
        logic             e_idle;
        logic [3:0][31:0] e_data;
    } vec_t;

    vec_t vecs [33];

    function automatic vec_t mk(logic v, logic [1:0] dir, logic [31:0] data, logic [3:0] rdy,
                                logic e_rdy, logic [3:0] e_vld, logic e_idle,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                                logic [31:0] d3);
        vec_t r;
        r.v = v; r.dir = dir; r.data = data; r.rdy = rdy;
        r.e_rdy = e_rdy; r.e_vld = e_vld; r.e_idle = e_idle;
        r.e_data[0] = d0; r.e_data[1] = d1; r.e_data[2] = d2; r.e_data[3] = d3;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // rdy bits: [0]=north [1]=east [2]=south [3]=west
    task automatic step(logic v, logic [1:0] dir, logic [31:0] data, logic [3:0] rdy);
        @(negedge clk_i);
        dist_valid_i = v; dist_dir_i = dir; dist_data_i = data;
        {w_ready, s_ready, e_ready, n_ready} = rdy;
        #1;
    endtask

    function automatic logic [3:0] vlds();
        return {w_valid, s_valid, e_valid, n_valid};
    endfunction

    function automatic logic [31:0] head(int d);
        case (d)
            0:       return n_data;
            1:       return e_data;
            2:       return s_data;
            default: return w_data;
        endcase
    endfunction

    task automatic chk_reset_state(string tag);
        chk({tag, "_rdy"}, 32'(dist_ready_o), 32'd1);
        chk({tag, "_vld"}, 32'(vlds()), 32'd0);
        chk({tag, "_idle"}, 32'(idle_o), 32'd1);
        for (int d = 0; d < 4; d++) chk($sformatf("%s_data%0d", tag, d), head(d), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        dist_valid_i = 1'b0; dist_dir_i = '0; dist_data_i = '0;
        {w_ready, s_ready, e_ready, n_ready} = 4'hF;

        // single east message, then four directions back to back
        vecs[0]  = mk(1, 1, 32'hA5A5A5A5, 4'hF, 1, 4'b0000, 1, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 4'hF, 1, 4'b0000, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 4'hF, 1, 4'b0010, 0, 0, 32'hA5A5A5A5, 0, 0);
        vecs[3]  = mk(0, 0, 0, 4'hF, 1, 4'b0000, 1, 0, 0, 0, 0);
        vecs[4]  = mk(1, 0, 32'h10, 4'hF, 1, 4'b0000, 1, 0, 0, 0, 0);
        vecs[5]  = mk(1, 1, 32'h11, 4'hF, 1, 4'b0000, 0, 0, 0, 0, 0);
        vecs[6]  = mk(1, 2, 32'h12, 4'hF, 1, 4'b0001, 0, 32'h10, 0, 0, 0);
        vecs[7]  = mk(1, 3, 32'h13, 4'hF, 1, 4'b0010, 0, 0, 32'h11, 0, 0);
        vecs[8]  = mk(0, 0, 0, 4'hF, 1, 4'b0100, 0, 0, 0, 32'h12, 0);
        vecs[9]  = mk(0, 0, 0, 4'hF, 1, 4'b1000, 0, 0, 0, 0, 32'h13);
        vecs[10] = mk(0, 0, 0, 4'hF, 1, 4'b0000, 1, 0, 0, 0, 0);
        // south blocked: two queued, one held, fourth waits
        vecs[11] = mk(1, 2, 32'h20, 4'b1011, 1, 4'b0000, 1, 0, 0, 0, 0);
        vecs[12] = mk(1, 2, 32'h21, 4'b1011, 1, 4'b0000, 0, 0, 0, 0, 0);
        vecs[13] = mk(1, 2, 32'h22, 4'b1011, 1, 4'b0100, 0, 0, 0, 32'h20, 0);
        vecs[14] = mk(1, 2, 32'h23, 4'b1011, 0, 4'b0100, 0, 0, 0, 32'h20, 0);
        vecs[15] = mk(1, 2, 32'h23, 4'b1011, 0, 4'b0100, 0, 0, 0, 32'h20, 0);
        vecs[16] = mk(1, 2, 32'h23, 4'hF, 0, 4'b0100, 0, 0, 0, 32'h20, 0);
        vecs[17] = mk(1, 2, 32'h23, 4'hF, 1, 4'b0100, 0, 0, 0, 32'h21, 0);
        vecs[18] = mk(0, 0, 0, 4'hF, 1, 4'b0100, 0, 0, 0, 32'h22, 0);
        vecs[19] = mk(0, 0, 0, 4'hF, 1, 4'b0100, 0, 0, 0, 32'h23, 0);
        vecs[20] = mk(0, 0, 0, 4'hF, 1, 4'b0000, 1, 0, 0, 0, 0);
        // head-of-line: south full with held south msg, north offer waits, north queue drains
        vecs[21] = mk(1, 0, 32'h40, 4'b0000, 1, 4'b0000, 1, 0, 0, 0, 0);
        vecs[22] = mk(1, 2, 32'h30, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
        vecs[23] = mk(1, 2, 32'h31, 4'b0000, 1, 4'b0001, 0, 32'h40, 0, 0, 0);
        vecs[24] = mk(1, 2, 32'h32, 4'b0000, 1, 4'b0101, 0, 32'h40, 0, 32'h30, 0);
        vecs[25] = mk(1, 0, 32'h41, 4'b0000, 0, 4'b0101, 0, 32'h40, 0, 32'h30, 0);
        vecs[26] = mk(1, 0, 32'h41, 4'b0001, 0, 4'b0101, 0, 32'h40, 0, 32'h30, 0);
        vecs[27] = mk(1, 0, 32'h41, 4'b0001, 0, 4'b0100, 0, 0, 0, 32'h30, 0);
        vecs[28] = mk(1, 0, 32'h41, 4'b0101, 0, 4'b0100, 0, 0, 0, 32'h30, 0);
        vecs[29] = mk(1, 0, 32'h41, 4'b0101, 1, 4'b0100, 0, 0, 0, 32'h31, 0);
        vecs[30] = mk(0, 0, 0, 4'b0101, 1, 4'b0100, 0, 0, 0, 32'h32, 0);
        vecs[31] = mk(0, 0, 0, 4'b0101, 1, 4'b0001, 0, 32'h41, 0, 0, 0);
        vecs[32] = mk(0, 0, 0, 4'b0101, 1, 4'b0000, 1, 0, 0, 0, 0);

        @(negedge clk_i); #1;
        chk_reset_state("in_reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk_reset_state("post_reset");

        for (int i = 0; i < 33; i++) begin
            step(vecs[i].v, vecs[i].dir, vecs[i].data, vecs[i].rdy);
            chk($sformatf("v%0d_rdy", i), 32'(dist_ready_o), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_vld", i), 32'(vlds()), 32'(vecs[i].e_vld));
            chk($sformatf("v%0d_idle", i), 32'(idle_o), 32'(vecs[i].e_idle));
            for (int d = 0; d < 4; d++) begin
                if (vecs[i].e_vld[d]) begin
                    chk($sformatf("v%0d_data%0d", i, d), head(d), vecs[i].e_data[d]);
                end
            end
        end

        // full south FIFO popped once while hold waits: push lands a cycle later
        step(1, 2, 32'h50, 4'b1011);
        step(1, 2, 32'h51, 4'b1011);
        step(1, 2, 32'h52, 4'b1011);
        step(0, 0, 0, 4'b1011);
        chk("dfr_full_rdy", 32'(dist_ready_o), 32'd0);
        step(0, 0, 0, 4'hF);
        chk("dfr_pop_rdy", 32'(dist_ready_o), 32'd0);
        chk("dfr_pop_head", s_data, 32'h50);
        step(0, 0, 0, 4'b1011);
        chk("dfr_lvl1_rdy", 32'(dist_ready_o), 32'd1);
        chk("dfr_lvl1_head", s_data, 32'h51);
        step(0, 0, 0, 4'b1011);
        chk("dfr_refill_head", s_data, 32'h51);
        chk("dfr_refill_idle", 32'(idle_o), 32'd0);
        step(0, 0, 0, 4'hF);
        chk("dfr_drain0", s_data, 32'h51);
        step(0, 0, 0, 4'hF);
        chk("dfr_drain1", s_data, 32'h52);
        chk("dfr_drain1_vld", 32'(s_valid), 32'd1);
        step(0, 0, 0, 4'hF);
        chk("dfr_empty_vld", 32'(vlds()), 32'd0);
        chk("dfr_empty_idle", 32'(idle_o), 32'd1);

        // reset with messages in hold and FIFOs
        step(1, 3, 32'h60, 4'b0000);
        step(1, 3, 32'h61, 4'b0000);
        step(1, 1, 32'h62, 4'b0000);
        step(1, 3, 32'h63, 4'b0000);
        step(0, 0, 0, 4'b0000);
        chk("rst_pre_rdy", 32'(dist_ready_o), 32'd0);
        chk("rst_pre_vld", 32'(vlds()), 32'b1010);
        @(negedge clk_i);
        rst_i = 1'b1;
        {w_ready, s_ready, e_ready, n_ready} = 4'hF;
        #1;
        chk_reset_state("mid_reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk_reset_state("mid_post_reset");
        step(1, 3, 32'h70, 4'hF);
        chk("rst_after_vld", 32'(vlds()), 32'd0);
        chk("rst_after_idle", 32'(idle_o), 32'd1);
        step(0, 0, 0, 4'hF);
        chk("rst_tr_hold_vld", 32'(vlds()), 32'd0);
        step(0, 0, 0, 4'hF);
        chk("rst_tr_vld", 32'(vlds()), 32'b1000);
        chk("rst_tr_data", w_data, 32'h70);
        step(0, 0, 0, 4'hF);
        chk("rst_tr_idle", 32'(idle_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
